lsu_ctrl: RTL
=============

LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 Parameter SPLIT_EN, default 1: 1 = accesses crossing an 8-byte boundary are split into two beats; 0 = such accesses return an error.
REQ-002 clock  in  1  single clock for all state.
REQ-003 reset  in  1  asynchronous, active-low.
REQ-004 req_valid  in  1  access request present.
REQ-005 req_ready  out  1  block can accept a request.
REQ-006 req_wen  in  1  1 = store, 0 = load.
REQ-007 req_size  in  2  access width: 0 = B, 1 = H, 2 = W, 3 = D.
REQ-008 req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
REQ-009 req_addr  in  64  byte address.
REQ-010 req_wdata  in  64  store data, right-justified.
REQ-011 resp_valid  out  1  single-cycle completion pulse.
REQ-012 resp_rdata  out  64  extended load result; 0 for stores and errors.
REQ-013 resp_err  out  1  valid with resp_valid; boundary-crossing access with SPLIT_EN=0.
REQ-014 mem_en  out  1  memory beat strobe.
REQ-015 mem_wen  out  1  beat is a write.
REQ-016 mem_addr  out  64  8-byte-aligned beat address.
REQ-017 mem_wdata  out  64  byte-lane-positioned write data.
REQ-018 mem_mask  out  64  bit mask, 0xFF per enabled byte lane, for reads and writes.
REQ-019 mem_rdata  in  64  read data, combinationally valid in the same cycle as mem_en.

Function
REQ-020 FSM states SHALL be IDLE, BEAT0, BEAT1 and RESP; all mem_* and resp_* outputs SHALL be registered or decoded from state only.
REQ-021 req_ready SHALL be 1 only in IDLE; req_valid outside IDLE SHALL be ignored.
REQ-022 Accept in IDLE SHALL latch wen, size, unsigned, addr and wdata, and compute off = addr[2:0], n = 1<<size, split = (off+n > 8).
REQ-023 IDLE->BEAT0 on accept unless split and SPLIT_EN=0, in which case IDLE->RESP with resp_err=1 and no mem_en.
REQ-024 BEAT0: mem_en=1, mem_addr={addr[63:3],000}, lanes off..min(off+n,8)-1 enabled, mem_wdata = wdata<<(8*off); loads capture mem_rdata>>(8*off); next state BEAT1 if split, else RESP.
REQ-025 BEAT1: mem_en=1, mem_addr = BEAT0 address + 8 (mod 2^64), lanes 0..off+n-9 enabled, mem_wdata = wdata>>(8*(8-off)); loads merge mem_rdata<<(8*(8-off)) above the BEAT0 bytes; next state RESP.
REQ-026 mem_en SHALL be high for exactly one cycle per beat; mem_wen = latched wen during beats, else 0.
REQ-027 RESP: resp_valid=1 for one cycle; resp_rdata = low n bytes sign- or zero-extended per size/unsigned; next state IDLE.
REQ-028 Latency from accept cycle N: aligned resp_valid at N+2; split at N+3; error at N+1; the next accept is possible at the cycle after resp_valid.
REQ-029 resp has no backpressure; the consumer SHALL take resp_valid when it is asserted.
REQ-030 Outside beats, mem_addr, mem_wdata and mem_mask SHALL be 0.

Reset
REQ-031 While reset=0: state IDLE, all outputs 0 except req_ready=1, and latched request cleared.
REQ-032 Reset asserted mid-access SHALL drop mem_en immediately (asynchronously), abandon remaining beats, and produce no resp_valid.

Verification
REQ-033 Byte signed load at 0x8000_0003, dword@0x8000_0000 = 0x1122_3344_8877_6655 -> one beat, mem_mask 0x0000_0000_FF00_0000, resp_rdata 0xFFFF_FFFF_FFFF_FF88 at N+2.
REQ-034 Unsigned half load at 0x8000_0002, same memory -> resp_rdata 0x0000_0000_0000_8877, resp_err=0.
REQ-035 Word store 0xDEAD_BEEF at 0x8000_0006 -> beat0 addr 0x8000_0000, mask 0xFFFF_0000_0000_0000, wdata[63:48]=0xBEEF; beat1 addr 0x8000_0008, mask 0x0000_0000_0000_FFFF, wdata[15:0]=0xDEAD; resp at N+3 with rdata 0.
REQ-036 Double load at 0x8000_0004, dword0 = 0x1122_3344_5566_7788, dword1 = 0x99AA_BBCC_DDEE_FF00 -> resp_rdata 0xDDEE_FF00_1122_3344 at N+3.
REQ-037 SPLIT_EN=0, word load at 0x8000_0006 -> no mem_en, resp_valid=1 and resp_err=1 at N+1.
REQ-038 Reset pulsed during BEAT0 of a split store -> mem_en low immediately, no BEAT1, no resp_valid, req_ready=1 while reset low and after release.

Source files
------------

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: splits 8-byte-boundary-crossing accesses into two aligned memory
// beats (or flags them as errors), positions store data by byte lane and extends load results.
module lsu_ctrl #(
  parameter int unsigned SPLIT_EN = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_en,
  output logic        mem_wen,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic [63:0] mem_mask,
  input  logic [63:0] mem_rdata
);

  localparam bit SplitOn = (SPLIT_EN != 0);

  typedef enum logic [1:0] {
    StIdle,
    StBeat0,
    StBeat1,
    StResp
  } state_e;

  state_e      state_q, state_d;
  logic        wen_q, wen_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [63:0] rdata_q, rdata_d;

  // Byte lanes touched by an access, as a 16-lane window over two consecutive dwords.
  function automatic logic [15:0] lane_span(input logic [1:0] size, input logic [2:0] off);
    logic [15:0] ones;
    case (size)
      2'd0:    ones = 16'h0001;
      2'd1:    ones = 16'h0003;
      2'd2:    ones = 16'h000F;
      default: ones = 16'h00FF;
    endcase
    return ones << off;
  endfunction

  function automatic logic [63:0] lane_to_bits(input logic [7:0] lanes);
    logic [63:0] m;
    for (int i = 0; i < 8; i++) begin
      m[8*i +: 8] = {8{lanes[i]}};
    end
    return m;
  endfunction

  function automatic logic [63:0] extend(input logic [63:0] d, input logic [1:0] size,
                                         input logic uns);
    logic [63:0] r;
    case (size)
      2'd0:    r = {{56{~uns & d[7]}}, d[7:0]};
      2'd1:    r = {{48{~uns & d[15]}}, d[15:0]};
      2'd2:    r = {{32{~uns & d[31]}}, d[31:0]};
      default: r = d;
    endcase
    return r;
  endfunction

  logic [15:0] req_span;
  logic        req_split;
  logic [15:0] span;
  logic        split;
  logic        acc_err;
  logic [6:0]  sh0;
  logic [6:0]  sh1;
  logic [63:0] base_addr;

  assign req_span  = lane_span(req_size, req_addr[2:0]);
  assign req_split = |req_span[15:8];
  assign span      = lane_span(size_q, addr_q[2:0]);
  assign split     = |span[15:8];
  assign acc_err   = split && !SplitOn;
  assign sh0       = {1'b0, addr_q[2:0], 3'b000};
  // Only used on the second beat, where the offset is never zero.
  assign sh1       = 7'd64 - sh0;
  assign base_addr = {addr_q[63:3], 3'b000};

  always_comb begin
    state_d    = state_q;
    wen_d      = wen_q;
    size_d     = size_q;
    uns_d      = uns_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_rdata = '0;
    mem_en     = 1'b0;
    mem_wen    = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_mask   = '0;

    unique case (state_q)
      StIdle: begin
        req_ready = 1'b1;
        if (req_valid) begin
          wen_d   = req_wen;
          size_d  = req_size;
          uns_d   = req_unsigned;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          rdata_d = '0;
          state_d = (req_split && !SplitOn) ? StResp : StBeat0;
        end
      end
      StBeat0: begin
        mem_en    = 1'b1;
        mem_wen   = wen_q;
        mem_addr  = base_addr;
        mem_mask  = lane_to_bits(span[7:0]);
        mem_wdata = wdata_q << sh0;
        if (!wen_q) begin
          rdata_d = mem_rdata >> sh0;
        end
        state_d = split ? StBeat1 : StResp;
      end
      StBeat1: begin
        mem_en    = 1'b1;
        mem_wen   = wen_q;
        mem_addr  = base_addr + 64'd8;
        mem_mask  = lane_to_bits(span[15:8]);
        mem_wdata = wdata_q >> sh1;
        if (!wen_q) begin
          rdata_d = rdata_q | (mem_rdata << sh1);
        end
        state_d = StResp;
      end
      StResp: begin
        resp_valid = 1'b1;
        resp_err   = acc_err;
        if (!acc_err && !wen_q) begin
          resp_rdata = extend(rdata_q, size_q, uns_q);
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      wen_q   <= 1'b0;
      size_q  <= 2'd0;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      wen_q   <= wen_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

endmodule
